gascon_permutation: RTL and testbench

//  Iterated Gascon permutation engine: loads a CWIDTH-bit state, applies R rounds
//  (round constant, s-box layer, linear layer), ROUNDS_PER_CYCLE rounds per clock, under an FSM.

---
 rtl/gascon_pkg.sv | 25 ++
 rtl/gascon_round.sv | 53 +++++
 rtl/gascon_permutation.sv | 102 ++++++++++
 tb/tb_gascon_permutation.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gascon_pkg.sv
// Shared types, rotation tables and helpers for the Gascon permutation engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gascon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Linear-layer rotation amounts per 64-bit word; the 192-bit state uses words 0..2.
    localparam int ROT0 [5] = '{19, 61, 1, 10, 7};
    localparam int ROT1 [5] = '{28, 39, 6, 17, 41};

    // Round constant: descending nibble above ascending nibble of the round index.
    function automatic logic [63:0] round_const(input logic [3:0] i);
        return {56'b0, 4'hf - i, i};
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int r);
        return (x >> r) | (x << (64 - r));
    endfunction

endpackage

// File: rtl/gascon_round.sv
// One Gascon round: round constant, s-box layer, linear layer.
// Latency: purely combinational.
// Backpressure: none; en=0 passes the state through untouched.
module gascon_round
    import gascon_pkg::*;
#(
    parameter int CWIDTH = 320
) (
    input  logic [CWIDTH-1:0] state_in,
    input  logic [3:0]        idx,
    input  logic              en,
    output logic [CWIDTH-1:0] state_out
);

    localparam int N   = CWIDTH / 64;
    localparam int MID = (N - 1) / 2;

    logic [63:0]       w [N];
    logic [63:0]       t [N];
    logic [CWIDTH-1:0] res;

    // Round datapath, written in the same step order as the algorithm description.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            w[k] = state_in[64*k +: 64];
        end
        w[MID] = w[MID] ^ round_const(idx);
        // s-box pre-mix; ascending order so w[0] sees the old w[N-1]
        for (int k = 0; k <= MID; k++) begin
            w[2*k] = w[2*k] ^ w[(2*k + N - 1) % N];
        end
        for (int j = 0; j < N; j++) begin
            t[j] = ~w[j] & w[(j + 1) % N];
        end
        for (int j = 0; j < N; j++) begin
            w[j] = w[j] ^ t[(j + 1) % N];
        end
        for (int k = 0; k < MID; k++) begin
            w[2*k+1] = w[2*k+1] ^ w[2*k];
        end
        w[0]   = w[0] ^ w[N-1];
        w[MID] = ~w[MID];
        for (int k = 0; k < N; k++) begin
            w[k] = w[k] ^ ror64(w[k], ROT0[k]) ^ ror64(w[k], ROT1[k]);
        end
        res = '0;
        for (int k = 0; k < N; k++) begin
            res[64*k +: 64] = w[k];
        end
        state_out = en ? res : state_in;
    end

endmodule

// File: rtl/gascon_permutation.sv
// Iterated Gascon permutation: runs the last R of ROUNDS_MAX rounds, ROUNDS_PER_CYCLE per clock.
// Latency: done asserts ceil(R_eff/RPC)+1 cycles after start is sampled (1 cycle for R_eff=0).
// Backpressure: start is taken only while ready (IDLE or DONE); start in RUN is ignored.
module gascon_permutation
    import gascon_pkg::*;
#(
    parameter int  CWIDTH           = 320,
    parameter int  ROUNDS_MAX       = 12,
    parameter int  ROUNDS_PER_CYCLE = 1,
    localparam int RW               = $clog2(ROUNDS_MAX + 1),
    localparam int IW               = $clog2(ROUNDS_MAX + ROUNDS_PER_CYCLE + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [RW-1:0]     rounds,
    input  logic              abort,
    input  logic [CWIDTH-1:0] state_in,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [CWIDTH-1:0] state_out
);

    localparam int RPC = ROUNDS_PER_CYCLE;

    state_e            fsm_q, fsm_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CWIDTH-1:0] st_q, st_d;
    logic [RW-1:0]     r_eff;
    logic [CWIDTH-1:0] chain [RPC+1];

    // Requests beyond the schedule length run the whole schedule.
    assign r_eff    = (rounds > RW'(ROUNDS_MAX)) ? RW'(ROUNDS_MAX) : rounds;
    assign chain[0] = st_q;

    // Unrolled round chain; stages past the end of the schedule pass through,
    // so a partial last cycle still applies exactly R_eff rounds.
    for (genvar g = 0; g < RPC; g++) begin : g_stage
        logic [31:0] sidx;
        assign sidx = 32'(idx_q) + 32'(g);
        gascon_round #(
            .CWIDTH(CWIDTH)
        ) u_round (
            .state_in (chain[g]),
            .idx      (sidx[3:0]),
            .en       (sidx < 32'(ROUNDS_MAX)),
            .state_out(chain[g+1])
        );
    end

    // Next-state: load on accepted start, iterate in RUN, abort always wins.
    always_comb begin
        fsm_d = fsm_q;
        idx_d = idx_q;
        st_d  = st_q;
        unique case (fsm_q)
            IDLE, DONE: begin
                if (abort) begin
                    fsm_d = IDLE;
                end else if (start) begin
                    st_d  = state_in;
                    idx_d = IW'(ROUNDS_MAX) - IW'(r_eff);
                    fsm_d = (r_eff == '0) ? DONE : RUN;
                end else begin
                    fsm_d = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    fsm_d = IDLE;
                end else begin
                    st_d  = chain[RPC];
                    idx_d = idx_q + IW'(RPC);
                    if (idx_q + IW'(RPC) >= IW'(ROUNDS_MAX)) begin
                        fsm_d = DONE;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // State, round index and permutation state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q <= IDLE;
            idx_q <= '0;
            st_q  <= '0;
        end else begin
            fsm_q <= fsm_d;
            idx_q <= idx_d;
            st_q  <= st_d;
        end
    end

    assign ready     = (fsm_q == IDLE) || (fsm_q == DONE);
    assign busy      = (fsm_q == RUN);
    assign done      = (fsm_q == DONE);
    assign state_out = st_q;

endmodule

// File: tb/tb_gascon_permutation.sv
// Bench for gascon_permutation: four builds (320b RPC 1/4/5, 192b RPC 1), one active at a time.
// Expected results and done cycles go into a scoreboard queue at issue; a negedge monitor pops them.
// Control-signal checks (reset, abort, start-in-RUN) are made directly by the stimulus process.
module tb_gascon_permutation;

    typedef struct {
        int           d;
        int           cyc;
        logic [319:0] val;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         start_a [4];
    logic         abort_a [4];
    logic [3:0]   rounds_a [4];
    logic [319:0] sin_a [4];
    logic         ready_a [4];
    logic         busy_a [4];
    logic         done_a [4];
    logic [319:0] sout0, sout1, sout2;
    logic [191:0] sout3;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    exp_t sb [$];
    exp_t mon_e;

    localparam logic [319:0] S1 = 320'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0_deadbeefcafef00d;
    localparam logic [319:0] S2 = 320'h5555aaaa3333cccc_00000000ffffffff_8000000000000001_1234000000005678_a5a5a5a55a5a5a5a;
    localparam logic [319:0] S3 = 320'hffffffffffffffff_0000000000000001_7f7f7f7f7f7f7f7f_0102030405060708_c3c3c3c33c3c3c3c;

    // Hand-derived single-round (index 11) results from an all-zero state.
    localparam logic [319:0] G320 = {64'h0000000000000000, 64'h12e580000000004b, 64'h53ffffffffffff90,
                                     64'h0000000096000213, 64'h000964b00000004b};
    localparam logic [319:0] G192 = {128'b0, 64'h0000000000000000, 64'hffffffff69fffdec, 64'h0000000000000000};

    gascon_permutation #(.CWIDTH(320), .ROUNDS_MAX(12), .ROUNDS_PER_CYCLE(1)) u_d0 (
        .clk(clk), .reset(reset), .start(start_a[0]), .rounds(rounds_a[0]), .abort(abort_a[0]),
        .state_in(sin_a[0]), .ready(ready_a[0]), .busy(busy_a[0]), .done(done_a[0]), .state_out(sout0));
    gascon_permutation #(.CWIDTH(320), .ROUNDS_MAX(12), .ROUNDS_PER_CYCLE(4)) u_d1 (
        .clk(clk), .reset(reset), .start(start_a[1]), .rounds(rounds_a[1]), .abort(abort_a[1]),
        .state_in(sin_a[1]), .ready(ready_a[1]), .busy(busy_a[1]), .done(done_a[1]), .state_out(sout1));
    gascon_permutation #(.CWIDTH(320), .ROUNDS_MAX(12), .ROUNDS_PER_CYCLE(5)) u_d2 (
        .clk(clk), .reset(reset), .start(start_a[2]), .rounds(rounds_a[2]), .abort(abort_a[2]),
        .state_in(sin_a[2]), .ready(ready_a[2]), .busy(busy_a[2]), .done(done_a[2]), .state_out(sout2));
    gascon_permutation #(.CWIDTH(192), .ROUNDS_MAX(12), .ROUNDS_PER_CYCLE(1)) u_d3 (
        .clk(clk), .reset(reset), .start(start_a[3]), .rounds(rounds_a[3]), .abort(abort_a[3]),
        .state_in(sin_a[3][191:0]), .ready(ready_a[3]), .busy(busy_a[3]), .done(done_a[3]), .state_out(sout3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rpc_of(input int d);
        return (d == 1) ? 4 : (d == 2) ? 5 : 1;
    endfunction

    function automatic int words_of(input int d);
        return (d == 3) ? 3 : 5;
    endfunction

    function automatic logic [319:0] out_of(input int d);
        case (d)
            0:       return sout0;
            1:       return sout1;
            2:       return sout2;
            default: return {128'b0, sout3};
        endcase
    endfunction

    function automatic int lat_of(input int d, input int r);
        int re;
        re = (r > 12) ? 12 : r;
        return (re + rpc_of(d) - 1) / rpc_of(d) + 1;
    endfunction

    function automatic logic [63:0] rr(input logic [63:0] v, input int r);
        logic [127:0] t;
        t = {v, v} >> r;
        return t[63:0];
    endfunction

    // Reference permutation over n words, final R rounds of a 12-round schedule.
    function automatic logic [319:0] model(input int n, input logic [319:0] s, input int r);
        logic [63:0]  w [5];
        logic [63:0]  x [5];
        logic [319:0] o;
        int           r0 [5];
        int           r1 [5];
        int           re;
        int           mid;
        r0  = '{19, 61, 1, 10, 7};
        r1  = '{28, 39, 6, 17, 41};
        re  = (r > 12) ? 12 : r;
        mid = (n - 1) / 2;
        for (int k = 0; k < 5; k++) w[k] = (k < n) ? s[64*k +: 64] : 64'b0;
        for (int i = 12 - re; i < 12; i++) begin
            w[mid] ^= {56'b0, 4'(15 - i), 4'(i)};
            for (int k = 0; k < n; k += 2) w[k] ^= w[(k + n - 1) % n];
            for (int j = 0; j < n; j++) x[j] = w[j] ^ (~w[(j + 1) % n] & w[(j + 2) % n]);
            for (int j = 0; j < n; j++) w[j] = x[j];
            for (int k = 1; k < n; k += 2) w[k] ^= w[k - 1];
            w[0] ^= w[n - 1];
            w[mid] = ~w[mid];
            for (int k = 0; k < n; k++) w[k] = w[k] ^ rr(w[k], r0[k]) ^ rr(w[k], r1[k]);
        end
        o = '0;
        for (int k = 0; k < n; k++) o[64*k +: 64] = w[k];
        return o;
    endfunction

    task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle; optionally register the expected result and done cycle.
    task automatic issue(input int d, input logic [3:0] r, input logic [319:0] s,
                         input bit expect_done, input logic [319:0] expv);
        exp_t e;
        start_a[d]  = 1'b1;
        rounds_a[d] = r;
        sin_a[d]    = s;
        if (expect_done) begin
            e.d   = d;
            e.cyc = cyc + lat_of(d, int'(r));
            e.val = expv;
            sb.push_back(e);
        end
        step();
        start_a[d] = 1'b0;
    endtask

    task automatic run_model(input int d, input logic [3:0] r, input logic [319:0] s);
        issue(d, r, s, 1'b1, model(words_of(d), s, int'(r)));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            step();
            t++;
        end
        chk("drain_pending", 320'(sb.size()), 320'd0);
        sb.delete();
        step();
    endtask

    // Monitor: every done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (done_a[d] === 1'b1) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL spurious_done: dut %0d cycle %0d got done=1 required done=0", d, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk($sformatf("done_dut_cycle dut%0d", d), {32'(d), 32'(cyc)}, {32'(mon_e.d), 32'(mon_e.cyc)});
                    chk($sformatf("state_out dut%0d", d), out_of(d), mon_e.val);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        for (int d = 0; d < 4; d++) begin
            start_a[d]  = 1'b0;
            abort_a[d]  = 1'b0;
            rounds_a[d] = 4'd0;
            sin_a[d]    = '0;
        end
        repeat (3) step();
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("reset_ctrl dut%0d", d), {ready_a[d], busy_a[d], done_a[d]}, 3'b100);
            chk($sformatf("reset_state dut%0d", d), out_of(d), 320'd0);
        end
        #3 reset = 1'b1;
        step();

        // Single round from zero state, both widths, against hand-derived values
        issue(0, 4'd1, 320'd0, 1'b1, G320);
        drain();
        issue(3, 4'd1, 320'd0, 1'b1, G192);
        drain();

        // Full permutation on every build, plus partial-cycle bypass cases
        for (int d = 0; d < 4; d++) begin
            run_model(d, 4'd12, S1);
            drain();
        end
        run_model(2, 4'd7, S2);
        drain();
        run_model(1, 4'd6, S3);
        drain();

        // R=0 passes through in one cycle; R=15 clamps to the full schedule
        issue(0, 4'd0, S2, 1'b1, S2);
        drain();
        run_model(0, 4'd15, S3);
        drain();
        run_model(1, 4'd15, S3);
        drain();

        // start during RUN is ignored
        run_model(0, 4'd12, S2);
        repeat (2) step();
        start_a[0]  = 1'b1;
        rounds_a[0] = 4'd3;
        sin_a[0]    = S3;
        step();
        start_a[0] = 1'b0;
        chk("start_in_run_busy", 320'(busy_a[0]), 320'd1);
        drain();

        // start in the DONE cycle is accepted back-to-back
        run_model(1, 4'd8, S1);
        repeat (lat_of(1, 8) - 1) step();
        chk("done_cycle_ready", {ready_a[1], done_a[1]}, 2'b11);
        run_model(1, 4'd3, S3);
        drain();

        // abort three cycles into a full run: IDLE next cycle, no done
        issue(0, 4'd12, S1, 1'b0, '0);
        repeat (2) step();
        abort_a[0] = 1'b1;
        step();
        abort_a[0] = 1'b0;
        chk("abort_idle", {ready_a[0], busy_a[0], done_a[0]}, 3'b100);
        repeat (16) step();
        run_model(0, 4'd4, S2);
        drain();

        // abort together with start in IDLE: abort wins
        start_a[0] = 1'b1;
        abort_a[0] = 1'b1;
        rounds_a[0] = 4'd5;
        step();
        start_a[0] = 1'b0;
        abort_a[0] = 1'b0;
        chk("abort_beats_start", {ready_a[0], busy_a[0]}, 2'b10);
        repeat (8) step();

        // asynchronous reset mid-RUN, then a fresh run
        issue(0, 4'd12, S3, 1'b0, '0);
        repeat (3) step();
        #2 reset = 1'b0;
        #1;
        chk("async_reset_ctrl", {ready_a[0], busy_a[0], done_a[0]}, 3'b100);
        chk("async_reset_state", out_of(0), 320'd0);
        step();
        #2 reset = 1'b1;
        repeat (20) step();
        run_model(0, 4'd6, S1);
        drain();
        run_model(3, 4'd6, S2);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
